// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers: lock state enum and the rotated
// priority search used by round-robin arbiters of up to MAX_IN requesters.
package arb_pkg;

    localparam int MAX_IN    = 16;
    localparam int MAX_SEL_W = 4;
    localparam int IDX_W     = MAX_SEL_W + 1;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

    // First set bit of mask scanning ptr, ptr+1, ... modulo n; ptr if mask is empty.
    function automatic logic [MAX_SEL_W-1:0] rr_next(
        input logic [MAX_SEL_W-1:0] ptr,
        input logic [MAX_IN-1:0]    mask,
        input logic [IDX_W-1:0]     n
    );
        logic [MAX_SEL_W-1:0] res;
        logic                 found;
        logic [IDX_W-1:0]     idx;
        res   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_IN; k++) begin
            idx = {1'b0, ptr} + IDX_W'(k);
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((IDX_W'(k) < n) && !found && mask[idx[MAX_SEL_W-1:0]]) begin
                res   = idx[MAX_SEL_W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational rotated-priority encoder: picks the first active request at
// or after i_ptr, wrapping modulo NUM_IN.
module rr_grant
    import arb_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [SEL_W-1:0]  o_grant,
    output logic              o_any
);

    logic [MAX_IN-1:0]    w_mask;
    logic [MAX_SEL_W-1:0] w_ptr;
    logic [MAX_SEL_W-1:0] w_res;

    // Widen request vector and pointer to the helper's fixed operand size.
    always_comb begin
        w_mask               = '0;
        w_mask[NUM_IN-1:0]   = i_req;
        w_ptr                = '0;
        w_ptr[SEL_W-1:0]     = i_ptr;
    end

    assign w_res   = rr_next(w_ptr, w_mask, IDX_W'(NUM_IN));
    assign o_grant = SEL_W'(w_res);
    assign o_any   = |i_req;

endmodule

// File: rtl/rr_stream_arbiter.sv
// N-input round-robin stream arbiter with a single registered output stage.
// Optional packet locking (hold grant until in_last) via RR_PACKET_LOCK_EN.
module rr_stream_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_IN = 4,
    parameter  int width  = 32,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*width-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [width-1:0]        out_data,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic               r_out_valid;
    logic [width-1:0]   r_out_data;
    logic               r_out_last;
    logic [SEL_W-1:0]   r_out_sel;
    logic [SEL_W-1:0]   r_ptr;

    logic [SEL_W-1:0]   w_rr_grant;
    logic               w_rr_any;
    logic [SEL_W-1:0]   w_grant;
    logic               w_any;
    logic               w_load_en;
    logic               w_accept;
    logic [SEL_W-1:0]   w_ptr_inc;
    logic [NUM_IN-1:0]  w_in_ready;
    logic [width-1:0]   w_win_data;
    logic               w_win_last;

`ifdef RR_PACKET_LOCK_EN
    lock_state_e        r_lock_state;
    logic [SEL_W-1:0]   r_lock_idx;
`endif

    rr_grant #(
        .NUM_IN (NUM_IN)
    ) u_rr_grant (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_any   (w_rr_any)
    );

    // Effective grant: locked index overrides the round-robin choice.
    always_comb begin
        w_grant = w_rr_grant;
        w_any   = w_rr_any;
`ifdef RR_PACKET_LOCK_EN
        if (r_lock_state == LOCK_LOCKED) begin
            w_grant = r_lock_idx;
            w_any   = in_valid[r_lock_idx];
        end else begin
            w_grant = w_rr_grant;
            w_any   = w_rr_any;
        end
`endif
    end

    assign w_load_en  = !r_out_valid || out_ready;
    assign w_accept   = rst_n && w_load_en && w_any;
    assign w_win_data = in_data[int'(w_grant)*width +: width];
    assign w_win_last = in_last[w_grant];

    // One-hot accept toward the winner; nothing while stalled or in reset.
    always_comb begin
        w_in_ready = '0;
        if (w_accept) begin
            w_in_ready[w_grant] = 1'b1;
        end else begin
            w_in_ready = '0;
        end
    end

    // Successor of the winner with explicit wrap for non-power-of-2 NUM_IN.
    always_comb begin
        w_ptr_inc = '0;
        if (w_grant == SEL_W'(NUM_IN - 1)) begin
            w_ptr_inc = '0;
        end else begin
            w_ptr_inc = w_grant + SEL_W'(1);
        end
    end

    // Output stage: load on accept, drop valid on drain, hold on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_win_data;
            r_out_last  <= w_win_last;
            r_out_sel   <= w_grant;
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Round-robin pointer; with locking it only moves at packet boundaries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
`ifdef RR_PACKET_LOCK_EN
            if (w_win_last) begin
                r_ptr <= w_ptr_inc;
            end else begin
                r_ptr <= r_ptr;
            end
`else
            r_ptr <= w_ptr_inc;
`endif
        end else begin
            r_ptr <= r_ptr;
        end
    end

`ifdef RR_PACKET_LOCK_EN
    // Lock tracking: a non-last beat pins the grant until that index sends last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock_state <= LOCK_UNLOCKED;
            r_lock_idx   <= '0;
        end else if (w_accept) begin
            if (w_win_last) begin
                r_lock_state <= LOCK_UNLOCKED;
                r_lock_idx   <= r_lock_idx;
            end else begin
                r_lock_state <= LOCK_LOCKED;
                r_lock_idx   <= w_grant;
            end
        end else begin
            r_lock_state <= r_lock_state;
            r_lock_idx   <= r_lock_idx;
        end
    end
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (NUM_IN=4, width=32); expectations
// follow RR_PACKET_LOCK_EN when the packet-lock sequence differs.
module tb_rr_stream_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [1:0]     out_sel;
    logic           out_ready;

    int n_total = 0;
    int n_pass  = 0;

    rr_stream_arbiter #(.NUM_IN(N), .width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic [31:0] exp_data;
        logic       exp_last;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 4'b0000;
        in_last  = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [2:0]  lk_sel  [6];
    logic        lk_last [6];

    initial begin
        int sent;
        logic rdy2;

        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
        rst_n = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        //              rst   valid    ordy  exp_rdy  ov    sel    data       last
        tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0,  1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'hA0, 1'b1};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'hA1, 1'b1};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'hA2, 1'b1};
        tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'hA3, 1'b1};
        tbl[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0, 1'b1};
        tbl[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0, 1'b1};
        tbl[8]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0, 1'b1};
        tbl[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'hA0, 1'b1};
        tbl[10] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1, 32'hA1, 1'b1};
        tbl[11] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd2, 32'hA2, 1'b1};
        tbl[12] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'hA1, 1'b1};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hA1, 1'b1};
        tbl[14] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b0, 2'd1, 32'hA1, 1'b1};
        tbl[15] = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 32'hA3, 1'b1};
        tbl[16] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0, 1'b1};
        tbl[17] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'hA0, 1'b1};
        tbl[18] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'hA0, 1'b1};
        tbl[19] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 32'h0,  1'b0};
        tbl[20] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 32'hA2, 1'b1};

        for (int v = 0; v < 21; v++) begin
            rst_n = tbl[v].rst_n; in_valid = tbl[v].valid;
            in_last = 4'b1111; out_ready = tbl[v].ordy;
            @(negedge clk);
            chk($sformatf("in_ready[v%0d]", v),  32'(in_ready),  32'(tbl[v].exp_rdy));
            chk($sformatf("out_valid[v%0d]", v), 32'(out_valid), 32'(tbl[v].exp_ov));
            chk($sformatf("out_sel[v%0d]", v),   32'(out_sel),   32'(tbl[v].exp_sel));
            chk($sformatf("out_data[v%0d]", v),  out_data,       tbl[v].exp_data);
            chk($sformatf("out_last[v%0d]", v),  32'(out_last),  32'(tbl[v].exp_last));
            @(posedge clk); #1;
        end

        // Index 2 sends a 3-beat packet while 0 and 1 stay valid.
`ifdef RR_PACKET_LOCK_EN
        lk_sel  = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd1, 3'd0};
        lk_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        lk_sel  = '{3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
        lk_last = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        do_reset();
        in_valid = 4'b0010; in_last = 4'b1111;
        @(posedge clk); #1;
        sent = 0;
        for (int k = 0; k < 7; k++) begin
            in_valid = {1'b0, (sent < 3), 2'b11};
            in_last  = {1'b1, (sent == 2), 2'b11};
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("pkt_valid[%0d]", k), 32'(out_valid), 32'd1);
                chk($sformatf("pkt_sel[%0d]", k),   32'(out_sel),   32'(lk_sel[k-1]));
                chk($sformatf("pkt_last[%0d]", k),  32'(out_last),  32'(lk_last[k-1]));
            end
            rdy2 = in_ready[2];
            @(posedge clk); #1;
            if (rdy2) sent++;
        end

        // Reset in the middle of a packet from index 2.
        do_reset();
        in_valid = 4'b0010; in_last = 4'b1111;
        @(posedge clk); #1;
        in_valid = 4'b0111; in_last = 4'b1011;
        @(negedge clk);
        chk("mid_first_grant", 32'(in_ready), 32'(4'b0100));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(in_ready), 32'(4'b0000));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sel",   32'(out_sel),   32'd0);
        chk("mid_rst_grant", 32'(in_ready),  32'(4'b0001));
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_after_sel",  32'(out_sel), 32'd0);
        chk("mid_after_data", out_data,     32'hA0);
        chk("mid_after_next", 32'(in_ready), 32'(4'b0010));
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
